// File: rtl/sopc_v3_butee_in_pkg.sv
// Shared constants for the end-stop input block:
// register word addresses and EDGE_SEL field layout.
package sopc_v3_butee_in_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

    localparam int FALL_OFS = 16;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_kind_t;

    // Classify one debounced bit against its previous-cycle value.
    function automatic edge_kind_t edge_of(input logic cur, input logic prev);
        if (cur && !prev) begin
            return EDGE_RISE;
        end
        if (!cur && prev) begin
            return EDGE_FALL;
        end
        return EDGE_NONE;
    endfunction

endpackage

// File: rtl/sopc_v3_butee_in_debounce.sv
// One end-stop line: 2-flop synchronizer, tick-sampled history,
// and a debounced level that moves only on a unanimous history.
module butee_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic level
);

    logic                   sync1;
    logic                   sync2;
    logic [DEB_SAMPLES-1:0] hist;
    logic [DEB_SAMPLES-1:0] hist_next;

    assign hist_next = {hist[DEB_SAMPLES-2:0], sync2};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist  <= '0;
            level <= 1'b0;
        end else if (tick) begin
            hist <= hist_next;
            if (&hist_next) begin
                level <= 1'b1;
            end else if (~|hist_next) begin
                level <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sopc_v3_butee_in.sv
// Avalon-MM end-stop input port: debounced levels, selectable
// edge capture with write-1-to-clear, and a masked level interrupt.
module sopc_v3_butee_in
    import sopc_v3_butee_in_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int DEB_DIV     = 5000,
    parameter int DEB_SAMPLES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [15:0] DIV_MAX = 16'(DEB_DIV - 1);

    logic [15:0]      pre_cnt;
    logic             tick;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] sel_rise;
    logic [WIDTH-1:0] sel_fall;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic             wr;

    assign wr   = chipselect && !write_n;
    assign tick = (pre_cnt == DIV_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        butee_debounce #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick),
            .raw    (in_port[i]),
            .level  (deb[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev <= '0;
        end else begin
            deb_prev <= deb;
        end
    end

    always_comb begin
        cap_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (edge_of(deb[i], deb_prev[i]))
                EDGE_RISE: cap_set[i] = sel_rise[i];
                EDGE_FALL: cap_set[i] = sel_fall[i];
                default:   cap_set[i] = 1'b0;
            endcase
        end
    end

    assign cap_clr = (wr && address == ADDR_EDGE_CAP) ?
                     writedata[WIDTH-1:0] : '0;

    // Clear is applied first so a same-cycle set survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            sel_rise <= '1;
            sel_fall <= '0;
        end else if (wr) begin
            if (address == ADDR_IRQ_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            if (address == ADDR_EDGE_SEL) begin
                sel_rise <= writedata[WIDTH-1:0];
                sel_fall <= writedata[FALL_OFS +: WIDTH];
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = deb;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap;
            default: begin
                readdata[WIDTH-1:0]          = sel_rise;
                readdata[FALL_OFS +: WIDTH]  = sel_fall;
            end
        endcase
    end

endmodule

// File: tb/tb_sopc_v3_butee_in.sv
// Directed bench for sopc_v3_butee_in with a short debounce
// (DEB_DIV=4, DEB_SAMPLES=3) so every path is reached quickly.
module tb_sopc_v3_butee_in;

    localparam int W = 12;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int total;
    int bad;

    sopc_v3_butee_in #(
        .WIDTH      (W),
        .DEB_DIV    (4),
        .DEB_SAMPLES(3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read, called away from the rising edge.
    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        rd(2'd0, d); chk("rst_data", d, 32'h0);
        rd(2'd1, d); chk("rst_mask", d, 32'h0);
        rd(2'd2, d); chk("rst_cap", d, 32'h0);
        rd(2'd3, d); chk("rst_sel", d, 32'h0000_0FFF);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rise();
        logic [31:0] d;
        int n;
        wr(2'd1, 32'h001);
        @(negedge clk);
        in_port[0] = 1'b1;
        n = 0;
        d = '0;
        while (n < 40 && d[0] !== 1'b1) begin
            @(negedge clk);
            n++;
            rd(2'd0, d);
        end
        total++;
        if (n < 10 || n > 15) begin
            bad++;
            $display("FAIL rise_latency: got %0d cycles want 10..15", n);
        end
        chk("rise_data", d, 32'h001);
        @(negedge clk);
        rd(2'd2, d); chk("rise_cap", d, 32'h001);
        chk("rise_irq", {31'd0, irq}, 32'h1);
        wr(2'd2, 32'h001);
        rd(2'd2, d); chk("rise_clr", d, 32'h0);
        chk("rise_irq_off", {31'd0, irq}, 32'h0);
        in_port[0] = 1'b0;
        repeat (20) @(negedge clk);
        rd(2'd0, d); chk("fall0_data", d, 32'h0);
        rd(2'd2, d); chk("fall0_nocap", d, 32'h0);
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        wr(2'd1, 32'h020);
        in_port[5] = 1'b1;
        repeat (3) @(negedge clk);
        in_port[5] = 1'b0;
        repeat (30) begin
            @(negedge clk);
            rd(2'd0, d);
            if (d !== 32'h0) break;
        end
        chk("glitch_data", d, 32'h0);
        rd(2'd2, d); chk("glitch_cap", d, 32'h0);
        chk("glitch_irq", {31'd0, irq}, 32'h0);
    endtask

    task automatic test_fall();
        logic [31:0] d;
        int n;
        wr(2'd3, 32'h0080_0000);
        wr(2'd1, 32'h080);
        in_port[7] = 1'b1;
        repeat (20) @(negedge clk);
        rd(2'd0, d); chk("fall_high", d, 32'h080);
        rd(2'd2, d); chk("fall_norise", d, 32'h0);
        in_port[7] = 1'b0;
        n = 0;
        d = 32'h080;
        while (n < 40 && d[7] !== 1'b0) begin
            @(negedge clk);
            n++;
            rd(2'd0, d);
        end
        chk("fall_data", d, 32'h0);
        @(negedge clk);
        rd(2'd2, d); chk("fall_cap", d, 32'h080);
        chk("fall_irq", {31'd0, irq}, 32'h1);
        wr(2'd3, 32'h0000_0FFF);
        rd(2'd2, d); chk("sel_keep_cap", d, 32'h080);
        wr(2'd2, 32'h080);
        rd(2'd2, d); chk("w1c_cap", d, 32'h0);
        chk("w1c_irq", {31'd0, irq}, 32'h0);
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        int n;
        wr(2'd1, 32'h000);
        in_port[3] = 1'b1;
        n = 0;
        d = '0;
        while (n < 40 && d[3] !== 1'b1) begin
            @(negedge clk);
            n++;
            rd(2'd0, d);
        end
        chk("race_data", d, 32'h008);
        rd(2'd2, d); chk("race_precap", d, 32'h0);
        // Clear strobe lands on the same edge that sets the capture.
        address    = 2'd2;
        writedata  = 32'h008;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(2'd2, d); chk("race_set_wins", d, 32'h008);
        wr(2'd1, 32'h008);
        chk("race_irq", {31'd0, irq}, 32'h1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int n;
        in_port[2] = 1'b1;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        rd(2'd0, d); chk("mid_data", d, 32'h0);
        rd(2'd2, d); chk("mid_cap", d, 32'h0);
        chk("mid_irq", {31'd0, irq}, 32'h0);
        rd(2'd3, d); chk("mid_sel", d, 32'h0000_0FFF);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        d = '0;
        while (n < 40 && d !== 32'h00C) begin
            @(negedge clk);
            n++;
            rd(2'd0, d);
            if (n == 11) chk("mid_early", d, 32'h0);
        end
        chk("mid_latency", n, 12);
        chk("mid_accept", d, 32'h00C);
        @(negedge clk);
        rd(2'd2, d); chk("mid_first_rise", d, 32'h00C);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_w1c_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
